// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared encodings for the pipeline hazard controller: sequencer states,
// forwarding-select codes, the zero register and the forward-select helper.
package pipeline_hazard_controller_pkg;

  // Sequencer states (2-bit, kept as plain constants for legacy compatibility)
  localparam logic [1:0] StInit   = 2'd0;
  localparam logic [1:0] StRun    = 2'd1;
  localparam logic [1:0] StDrain  = 2'd2;
  localparam logic [1:0] StHalted = 2'd3;

  // ALU operand forwarding selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // X31 reads as zero, so it never produces a dependency
  localparam logic [4:0] XZR = 5'd31;

  // MEM result wins over WB because it is the younger write to the register
  function automatic logic [1:0] fwd_sel(input logic       mem_we,
                                         input logic [4:0] mem_rd,
                                         input logic       wb_we,
                                         input logic [4:0] wb_rd,
                                         input logic [4:0] src);
    if (mem_we && (mem_rd != XZR) && (mem_rd == src)) begin
      return FWD_MEM;
    end else if (wb_we && (wb_rd != XZR) && (wb_rd == src)) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_hazard_forward_unit.sv
// Pure combinational forwarding selects and load-use hazard detection.
module hazard_forward_unit
  import pipeline_hazard_controller_pkg::*;
(
  input  logic [4:0] id_rn_i,
  input  logic [4:0] id_rm_i,
  input  logic       id_uses_rn_i,
  input  logic       id_uses_rm_i,
  input  logic [4:0] ex_rn_i,
  input  logic [4:0] ex_rm_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic       mem_reg_write_i,
  input  logic [4:0] mem_rd_i,
  input  logic       wb_reg_write_i,
  input  logic [4:0] wb_rd_i,
  output logic       load_use_o,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o
);

  // Load in EX whose destination is read by the instruction in ID
  always_comb begin
    load_use_o = ex_mem_read_i && (ex_rd_i != XZR) &&
                 ((id_uses_rn_i && (id_rn_i == ex_rd_i)) ||
                  (id_uses_rm_i && (id_rm_i == ex_rd_i)));
  end

  // Operand forwarding for both ALU inputs
  always_comb begin
    fwd_a_o = fwd_sel(mem_reg_write_i, mem_rd_i, wb_reg_write_i, wb_rd_i, ex_rn_i);
    fwd_b_o = fwd_sel(mem_reg_write_i, mem_rd_i, wb_reg_write_i, wb_rd_i, ex_rm_i);
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencer: warm-up after reset, load-use stalls, branch flushes,
// halt/drain, EX forwarding selects and saturating stall/flush counters.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int unsigned WARMUP = 4,
  parameter int unsigned DRAIN  = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       ID_rn,
  input  logic [4:0]       ID_rm,
  input  logic             ID_uses_rn,
  input  logic             ID_uses_rm,
  input  logic [4:0]       EX_rn,
  input  logic [4:0]       EX_rm,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_rd,
  input  logic             MEM_RegWrite,
  input  logic [4:0]       MEM_rd,
  input  logic             WB_RegWrite,
  input  logic [4:0]       WB_rd,
  input  logic             branch_taken,
  input  logic             halt_req,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             flush_EX_MEM,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned PhaseMax = (WARMUP > DRAIN) ? WARMUP : DRAIN;
  localparam int unsigned PhaseW   = (PhaseMax > 1) ? $clog2(PhaseMax) : 1;

  logic [1:0]        state_q, state_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
  logic              stall_inc, flush_inc;
  logic              load_use;
  logic [1:0]        fwd_a, fwd_b;

  hazard_forward_unit u_hazard_forward_unit (
    .id_rn_i         (ID_rn),
    .id_rm_i         (ID_rm),
    .id_uses_rn_i    (ID_uses_rn),
    .id_uses_rm_i    (ID_uses_rm),
    .ex_rn_i         (EX_rn),
    .ex_rm_i         (EX_rm),
    .ex_mem_read_i   (EX_MemRead),
    .ex_rd_i         (EX_rd),
    .mem_reg_write_i (MEM_RegWrite),
    .mem_rd_i        (MEM_rd),
    .wb_reg_write_i  (WB_RegWrite),
    .wb_rd_i         (WB_rd),
    .load_use_o      (load_use),
    .fwd_a_o         (fwd_a),
    .fwd_b_o         (fwd_b)
  );

  // Forward selects read as register file while reset is held
  always_comb begin
    ForwardA = reset_n ? fwd_a : FWD_RF;
    ForwardB = reset_n ? fwd_b : FWD_RF;
  end

  // Next state, phase counter and per-cycle pipeline controls
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    PC_write     = 1'b0;
    IF_ID_write  = 1'b0;
    flush_IF_ID  = 1'b0;
    flush_ID_EX  = 1'b0;
    flush_EX_MEM = 1'b0;
    halted       = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    case (state_q)
      StInit: begin
        flush_IF_ID  = 1'b1;
        flush_ID_EX  = 1'b1;
        flush_EX_MEM = 1'b1;
        if (phase_q == PhaseW'(WARMUP - 1)) begin
          state_d = StRun;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PhaseW'(1);
        end
      end
      StRun, StDrain: begin
        if (branch_taken) begin
          // Redirect wins over a stall: the stalled instruction is flushed anyway
          PC_write     = 1'b1;
          IF_ID_write  = 1'b1;
          flush_IF_ID  = 1'b1;
          flush_ID_EX  = 1'b1;
          flush_EX_MEM = 1'b1;
          flush_inc    = 1'b1;
        end else if (load_use) begin
          flush_ID_EX = 1'b1;
          stall_inc   = 1'b1;
        end else if (state_q == StDrain) begin
          IF_ID_write = 1'b1;
          flush_IF_ID = 1'b1;
        end else begin
          PC_write    = 1'b1;
          IF_ID_write = 1'b1;
        end
        if (state_q == StRun) begin
          if (halt_req) begin
            state_d = StDrain;
            phase_d = '0;
          end
        end else if (!stall_inc) begin
          // A stall cycle injects no new bubble at IF_ID, so it does not count
          if (phase_q == PhaseW'(DRAIN - 1)) begin
            state_d = StHalted;
            phase_d = '0;
          end else begin
            phase_d = phase_q + PhaseW'(1);
          end
        end
      end
      StHalted: begin
        halted = 1'b1;
        if (!halt_req) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d = StInit;
        phase_d = '0;
      end
    endcase
  end

  // Sequencer state and phase counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StInit;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller with a behavioural model checked
// on every falling clock edge plus hand-computed literal expectations.
module tb_pipeline_hazard_controller;

  localparam int unsigned WARMUP = 4;
  localparam int unsigned DRAIN  = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int          CMAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [4:0]       ID_rn, ID_rm, EX_rn, EX_rm, EX_rd, MEM_rd, WB_rd;
  logic             ID_uses_rn, ID_uses_rm, EX_MemRead, MEM_RegWrite, WB_RegWrite;
  logic             branch_taken, halt_req;
  logic             PC_write, IF_ID_write, flush_IF_ID, flush_ID_EX, flush_EX_MEM, halted;
  logic [1:0]       ForwardA, ForwardB;
  logic [CNT_W-1:0] stall_count, flush_count;

  int vectors = 0;
  int miscompares = 0;

  pipeline_hazard_controller #(.WARMUP(WARMUP), .DRAIN(DRAIN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .ID_rn(ID_rn), .ID_rm(ID_rm), .ID_uses_rn(ID_uses_rn), .ID_uses_rm(ID_uses_rm),
    .EX_rn(EX_rn), .EX_rm(EX_rm), .EX_MemRead(EX_MemRead), .EX_rd(EX_rd),
    .MEM_RegWrite(MEM_RegWrite), .MEM_rd(MEM_rd), .WB_RegWrite(WB_RegWrite), .WB_rd(WB_rd),
    .branch_taken(branch_taken), .halt_req(halt_req),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .flush_IF_ID(flush_IF_ID),
    .flush_ID_EX(flush_ID_EX), .flush_EX_MEM(flush_EX_MEM),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .halted(halted),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Small PC register fed by the DUT enables, to observe hold/increment
  logic [31:0] pc;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)      pc <= 32'h0;
    else if (PC_write) pc <= branch_taken ? 32'h100 : pc + 32'd4;
  end

  // ---------------- behavioural model ----------------
  // Cycles of warm-up left, drain bubbles left, halted flag, counters.
  int warm_left = WARMUP, drain_left = 0, stalls_m = 0, flushes_m = 0;
  bit draining = 0, halted_m = 0;
  int n_warm, n_drain, n_stalls, n_flushes;
  bit n_draining, n_halted;

  function automatic logic [1:0] fwd_exp(input logic [4:0] src);
    if (MEM_RegWrite && MEM_rd != 5'd31 && MEM_rd == src) return 2'b10;
    if (WB_RegWrite && WB_rd != 5'd31 && WB_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm_left <= WARMUP; drain_left <= 0; draining <= 0; halted_m <= 0;
      stalls_m <= 0; flushes_m <= 0;
    end else begin
      warm_left <= n_warm; drain_left <= n_drain; draining <= n_draining;
      halted_m <= n_halted; stalls_m <= n_stalls; flushes_m <= n_flushes;
    end
  end

  logic       e_pc, e_if, e_f1, e_f2, e_f3, e_h, lu;
  logic [1:0] e_fa, e_fb;

  // Compare every cycle on the falling edge, then predict the next edge
  always @(negedge clk) begin
    n_warm = warm_left; n_drain = drain_left; n_draining = draining;
    n_halted = halted_m; n_stalls = stalls_m; n_flushes = flushes_m;
    lu = EX_MemRead && EX_rd != 5'd31 &&
         ((ID_uses_rn && ID_rn == EX_rd) || (ID_uses_rm && ID_rm == EX_rd));
    e_fa = reset_n ? fwd_exp(EX_rn) : 2'b00;
    e_fb = reset_n ? fwd_exp(EX_rm) : 2'b00;
    {e_pc, e_if, e_f1, e_f2, e_f3, e_h} = 6'b00_000_0;
    if (!reset_n || warm_left > 0) begin
      {e_f1, e_f2, e_f3} = 3'b111;
      if (reset_n) n_warm = warm_left - 1;
    end else if (halted_m) begin
      e_h = 1'b1;
      if (!halt_req) n_halted = 0;
    end else begin
      if (branch_taken) begin
        {e_pc, e_if, e_f1, e_f2, e_f3} = 5'b11111;
        if (flushes_m < CMAX) n_flushes = flushes_m + 1;
      end else if (lu) begin
        e_f2 = 1'b1;
        if (stalls_m < CMAX) n_stalls = stalls_m + 1;
      end else if (draining) begin
        {e_if, e_f1} = 2'b11;
      end else begin
        {e_pc, e_if} = 2'b11;
      end
      if (!draining) begin
        if (halt_req) begin n_draining = 1; n_drain = DRAIN; end
      end else if (branch_taken || !lu) begin
        n_drain = drain_left - 1;
        if (n_drain == 0) begin n_draining = 0; n_halted = 1; end
      end
    end
    chk("PC_write", 32'(PC_write), 32'(e_pc));
    chk("IF_ID_write", 32'(IF_ID_write), 32'(e_if));
    chk("flush_IF_ID", 32'(flush_IF_ID), 32'(e_f1));
    chk("flush_ID_EX", 32'(flush_ID_EX), 32'(e_f2));
    chk("flush_EX_MEM", 32'(flush_EX_MEM), 32'(e_f3));
    chk("halted", 32'(halted), 32'(e_h));
    chk("ForwardA", 32'(ForwardA), 32'(e_fa));
    chk("ForwardB", 32'(ForwardB), 32'(e_fb));
    chk("stall_count", 32'(stall_count), reset_n ? 32'(stalls_m) : 32'd0);
    chk("flush_count", 32'(flush_count), reset_n ? 32'(flushes_m) : 32'd0);
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {ID_rn, ID_rm, EX_rn, EX_rm, EX_rd, MEM_rd, WB_rd} = '0;
    {ID_uses_rn, ID_uses_rm, EX_MemRead, MEM_RegWrite, WB_RegWrite, branch_taken} = '0;
  endtask

  logic [31:0] pc_held;

  initial begin
    idle();
    halt_req = 1'b0;
    // Forwarding condition present during reset must still read 00
    MEM_RegWrite = 1'b1; EX_rn = 5'd3; MEM_rd = 5'd3;
    step(); step(); #1;
    chk("rst_PC_write", 32'(PC_write), 32'd0);
    chk("rst_flush_IF_ID", 32'(flush_IF_ID), 32'd1);
    chk("rst_ForwardA", 32'(ForwardA), 32'd0);
    idle();
    @(posedge clk); #1 reset_n = 1'b1;

    // 1. Warm-up: four held cycles, fetch on the fifth
    for (int i = 0; i < 4; i++) begin
      #1 chk("warm_PC_write", 32'(PC_write), 32'd0);
      chk("warm_flush_EX_MEM", 32'(flush_EX_MEM), 32'd1);
      step();
    end
    #1 chk("run_PC_write", 32'(PC_write), 32'd1);
    chk("run_halted", 32'(halted), 32'd0);

    // 2. LDUR X2 in EX, ADD X3,X2,X4 in ID
    EX_MemRead = 1'b1; EX_rd = 5'd2;
    ID_rn = 5'd2; ID_uses_rn = 1'b1; ID_rm = 5'd4; ID_uses_rm = 1'b1;
    #1 chk("lu_PC_write", 32'(PC_write), 32'd0);
    chk("lu_flush_ID_EX", 32'(flush_ID_EX), 32'd1);
    step();
    chk("lu_stall_count", 32'(stall_count), 32'd1);
    EX_MemRead = 1'b0; EX_rd = 5'd0; MEM_RegWrite = 1'b1; MEM_rd = 5'd2;   // bubble in EX
    #1 chk("lu_resume", 32'(PC_write), 32'd1);
    step();
    idle();
    EX_rn = 5'd2; EX_rm = 5'd4; WB_RegWrite = 1'b1; WB_rd = 5'd2;         // ADD in EX
    #1 chk("lu_fwdA_wb", 32'(ForwardA), 32'h1);
    chk("lu_fwdB_rf", 32'(ForwardB), 32'h0);
    step();

    // 3. ADD X5 in MEM, SUB X6,X5,X5 in EX (WB also writes X5: MEM wins)
    idle();
    MEM_RegWrite = 1'b1; MEM_rd = 5'd5; WB_RegWrite = 1'b1; WB_rd = 5'd5;
    EX_rn = 5'd5; EX_rm = 5'd5;
    #1 chk("fwdA_mem", 32'(ForwardA), 32'h2);
    chk("fwdB_mem", 32'(ForwardB), 32'h2);
    step();
    MEM_rd = 5'd31;
    #1 chk("fwdA_wb_fallthru", 32'(ForwardA), 32'h1);
    step();
    WB_rd = 5'd31;
    #1 chk("fwdA_xzr", 32'(ForwardA), 32'h0);
    chk("fwdB_xzr", 32'(ForwardB), 32'h0);
    step();

    // Load into XZR: no stall
    idle();
    EX_MemRead = 1'b1; EX_rd = 5'd31; ID_rn = 5'd31; ID_uses_rn = 1'b1;
    #1 chk("xzr_no_stall", 32'(PC_write), 32'd1);
    step();

    // 4. Taken branch with a simultaneous load-use hazard
    idle();
    branch_taken = 1'b1; EX_MemRead = 1'b1; EX_rd = 5'd7; ID_rm = 5'd7; ID_uses_rm = 1'b1;
    #1 chk("br_PC_write", 32'(PC_write), 32'd1);
    chk("br_flushes", 32'({flush_IF_ID, flush_ID_EX, flush_EX_MEM}), 32'h7);
    step();
    chk("br_stall_count", 32'(stall_count), 32'd1);
    chk("br_flush_count", 32'(flush_count), 32'd1);
    idle();

    // 5. halt_req for 10 cycles: 1 RUN, 4 DRAIN, then HALTED
    halt_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1 chk("halt_halted", 32'(halted), 32'(i >= 5));
      chk("halt_PC_write", 32'(PC_write), 32'(i == 0));
      if (i >= 1 && i <= 4) chk("drain_flush_IF_ID", 32'(flush_IF_ID), 32'd1);
      if (i == 5) pc_held = pc;
      step();
    end
    chk("halt_pc_held", pc, pc_held);
    halt_req = 1'b0;
    #1 chk("release_still_halted", 32'(halted), 32'd1);
    step();
    #1 chk("release_PC_write", 32'(PC_write), 32'd1);
    chk("release_halted", 32'(halted), 32'd0);
    step();
    chk("release_pc_plus4", pc, pc_held + 32'd4);

    // 6. Reset asserted mid-drain, between clock edges
    halt_req = 1'b1;
    step(); step();
    MEM_RegWrite = 1'b1; MEM_rd = 5'd9; EX_rn = 5'd9;
    #2 reset_n = 1'b0;
    #1 chk("mid_rst_PC_write", 32'(PC_write), 32'd0);
    chk("mid_rst_flushes", 32'({flush_IF_ID, flush_ID_EX, flush_EX_MEM}), 32'h7);
    chk("mid_rst_ForwardA", 32'(ForwardA), 32'd0);
    chk("mid_rst_stall_count", 32'(stall_count), 32'd0);
    chk("mid_rst_flush_count", 32'(flush_count), 32'd0);
    halt_req = 1'b0;
    idle();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    #1 chk("rerun_PC_write", 32'(PC_write), 32'd1);

    // Counter saturation with a 4-bit counter
    EX_MemRead = 1'b1; EX_rd = 5'd1; ID_rn = 5'd1; ID_uses_rn = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("stall_saturate", 32'(stall_count), 32'hF);
    idle();
    branch_taken = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("flush_saturate", 32'(flush_count), 32'hF);
    idle();
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule
